// File: rtl/ebp_frame_reader_if.sv
// Handshake and byte-memory bundle for the EBP-relative frame reader.
// slave = the reader; master = execute stage plus data memory.
interface ebp_frame_reader_if;
  logic [31:0] ebp;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_disp;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  ebp,
    input  req_valid,
    output req_ready,
    input  req_disp,
    input  req_size,
    input  req_signed,
    output mem_rd,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output rsp_valid,
    input  rsp_ready,
    output rsp_data,
    output rsp_err
  );

  modport master (
    output ebp,
    output req_valid,
    input  req_ready,
    output req_disp,
    output req_size,
    output req_signed,
    input  mem_rd,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_data,
    input  rsp_err
  );
endinterface

// File: rtl/ebp_frame_reader.sv
// EBP-relative load unit: fetches 1/2/4 bytes at ebp+disp8, little-endian.
// Optional FRAME_READ_TIMEOUT_EN aborts a stalled byte read with rsp_err.
module ebp_frame_reader #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  ebp_frame_reader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_rd_q, mem_rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] base_q, base_d;
  logic [31:0] asm_q, asm_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  last_q, last_d;
  logic        sgn_q, sgn_d;
  logic [31:0] asm_ack;
  logic [31:0] sext_disp;
  logic [1:0]  last_req;

`ifdef FRAME_READ_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  function automatic logic [31:0] extend(
    input logic [31:0] v,
    input logic [1:0]  last,
    input logic        sgn
  );
    logic [31:0] r;
    r = v;
    unique case (1'b1)
      last == 2'd0: r = {{24{sgn & v[7]}}, v[7:0]};
      last == 2'd1: r = {{16{sgn & v[15]}}, v[15:0]};
      default:      r = v;
    endcase
    return r;
  endfunction

  assign sext_disp = {{24{bus.req_disp[7]}}, bus.req_disp};

  always_comb begin
    last_req = 2'd3;
    unique case (1'b1)
      bus.req_size == 2'b00: last_req = 2'd0;
      bus.req_size == 2'b01: last_req = 2'd1;
      default:               last_req = 2'd3;
    endcase
  end

  always_comb begin
    asm_ack = asm_q;
    asm_ack[{idx_q, 3'b000} +: 8] = bus.mem_rdata;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    base_d      = base_q;
    asm_d       = asm_q;
    idx_d       = idx_q;
    last_d      = last_q;
    sgn_d       = sgn_q;
`ifdef FRAME_READ_TIMEOUT_EN
    wait_d      = wait_q;
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        mem_rd_d    = 1'b0;
        if (bus.req_valid && req_ready_q) begin
          base_d      = bus.ebp + sext_disp;
          mem_addr_d  = bus.ebp + sext_disp;
          last_d      = last_req;
          sgn_d       = bus.req_signed;
          asm_d       = '0;
          idx_d       = 2'd0;
          req_ready_d = 1'b0;
          mem_rd_d    = 1'b1;
          state_d     = READ;
`ifdef FRAME_READ_TIMEOUT_EN
          wait_d      = '0;
`endif
        end
      end

      READ: begin
        if (bus.mem_ack) begin
          asm_d = asm_ack;
          idx_d = idx_q + 2'd1;
`ifdef FRAME_READ_TIMEOUT_EN
          wait_d = '0;
`endif
          if (idx_q == last_q) begin
            mem_rd_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = extend(asm_ack, last_q, sgn_q);
            state_d     = RESP;
          end else begin
            // Base plus index wraps naturally mod 2^32
            mem_addr_d = base_q + 32'(idx_q + 2'd1);
          end
        end
`ifdef FRAME_READ_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_rd_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
`ifdef FRAME_READ_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_rd_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      base_q      <= '0;
      asm_q       <= '0;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      sgn_q       <= 1'b0;
`ifdef FRAME_READ_TIMEOUT_EN
      wait_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      base_q      <= base_d;
      asm_q       <= asm_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      sgn_q       <= sgn_d;
`ifdef FRAME_READ_TIMEOUT_EN
      wait_q      <= wait_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef FRAME_READ_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ebp_frame_reader.sv
// Scoreboard bench for ebp_frame_reader: directed loads, byte-memory model,
// response monitor decoupled from stimulus.
module tb_ebp_frame_reader;

  logic clock;
  logic reset;
  ebp_frame_reader_if mif ();

  ebp_frame_reader #(.TIMEOUT_CYCLES(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (mif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  logic [32:0] sb[$];
  logic [31:0] exp_addr[$];
  logic [7:0]  mem_dat[$];
  int          wait_states = 0;
  bit          mem_dead = 1'b0;

  task automatic chk(input string name, input logic [32:0] act,
                     input logic [32:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory responder: checks addresses, inserts wait states
  initial begin
    int wcnt;
    wcnt = 0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 8'h00;
    forever begin
      @(negedge clock);
      if (!mem_dead && mif.mem_rd === 1'b1) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_mem_rd", {32'h0, mif.mem_rd}, 33'h0);
          mif.mem_ack = 1'b0;
        end else begin
          chk("mem_addr", {1'b0, mif.mem_addr}, {1'b0, exp_addr[0]});
          if (wcnt < wait_states) begin
            mif.mem_ack = 1'b0;
            wcnt++;
          end else begin
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = mem_dat.pop_front();
            void'(exp_addr.pop_front());
            wcnt = 0;
          end
        end
      end else begin
        mif.mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Response monitor: data must match and hold until taken
  initial begin
    forever begin
      @(negedge clock);
      if (mif.rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {32'h0, mif.rsp_valid}, 33'h0);
        end else begin
          chk("rsp_data_err", {mif.rsp_err, mif.rsp_data}, sb[0]);
          if (mif.rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic load(input logic [31:0] e, input logic [7:0] d,
                      input logic [1:0] sz, input logic sg,
                      input logic [31:0] a0, input int n,
                      input logic [31:0] dw, input logic [32:0] exp);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a0 + 32'(i));
      mem_dat.push_back(dw[8*i +: 8]);
    end
    sb.push_back(exp);
    @(posedge clock);
    #1;
    chk("req_ready_idle", {32'h0, mif.req_ready}, 33'h1);
    mif.ebp        = e;
    mif.req_disp   = d;
    mif.req_size   = sz;
    mif.req_signed = sg;
    mif.req_valid  = 1'b1;
    @(posedge clock);
    #1;
    mif.req_valid = 1'b0;
    mif.ebp       = 32'hDEAD_BEEF;
    mif.req_disp  = 8'h55;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || exp_addr.size() != 0) && n < 300) begin
      @(posedge clock);
      n++;
    end
    chk("drain_sb_empty", 33'(sb.size()), 33'h0);
    chk("drain_mem_empty", 33'(exp_addr.size()), 33'h0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset          = 1'b1;
    mif.ebp        = '0;
    mif.req_valid  = 1'b0;
    mif.req_disp   = '0;
    mif.req_size   = '0;
    mif.req_signed = 1'b0;
    mif.rsp_ready  = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", {32'h0, mif.req_ready}, 33'h1);
    chk("rst_mem_rd",    {32'h0, mif.mem_rd},    33'h0);
    chk("rst_mem_addr",  {1'b0, mif.mem_addr},   33'h0);
    chk("rst_rsp_valid", {32'h0, mif.rsp_valid}, 33'h0);
    chk("rst_rsp_data",  {1'b0, mif.rsp_data},   33'h0);
    chk("rst_rsp_err",   {32'h0, mif.rsp_err},   33'h0);

    // 1: dword, negative displacement, latency 4
    load(32'h0000_0999, 8'hF8, 2'b10, 1'b0, 32'h0000_0991, 4,
         32'h1122_3344, 33'h0_1122_3344);
    repeat (3) @(posedge clock);
    #1 chk("t1_no_rsp_edge3", {32'h0, mif.rsp_valid}, 33'h0);
    @(posedge clock);
    #1 chk("t1_rsp_edge4", {32'h0, mif.rsp_valid}, 33'h1);
    chk("t1_mem_rd_low", {32'h0, mif.mem_rd}, 33'h0);
    drain();

    // 2: byte signed / unsigned
    load(32'h0000_1000, 8'h04, 2'b00, 1'b1, 32'h0000_1004, 1,
         32'h0000_0080, 33'h0_FFFF_FF80);
    @(posedge clock);
    #1 chk("t2_rsp_edge1", {32'h0, mif.rsp_valid}, 33'h1);
    drain();
    load(32'h0000_1000, 8'h04, 2'b00, 1'b0, 32'h0000_1004, 1,
         32'h0000_0080, 33'h0_0000_0080);
    drain();

    // 3: word load wrapping through zero, signed
    load(32'hFFFF_FFFE, 8'h01, 2'b01, 1'b1, 32'hFFFF_FFFF, 2,
         32'h0000_CDAB, 33'h0_FFFF_CDAB);
    drain();

    // size 11 treated as dword
    load(32'h0000_0400, 8'h7F, 2'b11, 1'b1, 32'h0000_047F, 4,
         32'h8765_4321, 33'h0_8765_4321);
    drain();

    // 4: wait states plus consumer back-pressure
    wait_states   = 3;
    mif.rsp_ready = 1'b0;
    load(32'h0000_2000, 8'h10, 2'b10, 1'b0, 32'h0000_2010, 4,
         32'hA1B2_C3D4, 33'h0_A1B2_C3D4);
    n = 0;
    while (mif.rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clock);
      chk("t4_req_ready_busy", {32'h0, mif.req_ready}, 33'h0);
      n++;
    end
    chk("t4_rsp_seen", {32'h0, mif.rsp_valid}, 33'h1);
    repeat (5) begin
      @(negedge clock);
      chk("t4_req_ready_hold", {32'h0, mif.req_ready}, 33'h0);
      chk("t4_mem_rd_hold", {32'h0, mif.mem_rd}, 33'h0);
    end
    @(posedge clock);
    #1 mif.rsp_ready = 1'b1;
    drain();
    repeat (4) @(posedge clock);
    #1 chk("t4_single_rsp", {32'h0, mif.rsp_valid}, 33'h0);

    // 5: reset during second byte of a dword
    load(32'h0000_3000, 8'h00, 2'b10, 1'b0, 32'h0000_3000, 4,
         32'h5566_7788, 33'h0_5566_7788);
    n = 0;
    while (exp_addr.size() != 3 && n < 100) begin
      @(posedge clock);
      n++;
    end
    chk("t5_first_byte_done", 33'(exp_addr.size()), 33'h3);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("t5_mem_rd_low", {32'h0, mif.mem_rd}, 33'h0);
    chk("t5_req_ready", {32'h0, mif.req_ready}, 33'h1);
    chk("t5_rsp_valid", {32'h0, mif.rsp_valid}, 33'h0);
    sb.delete();
    exp_addr.delete();
    mem_dat.delete();
    wait_states = 0;
    repeat (3) @(posedge clock);
    #1 chk("t5_idle_no_rd", {32'h0, mif.mem_rd}, 33'h0);
    load(32'h0000_1000, 8'h04, 2'b00, 1'b1, 32'h0000_1004, 1,
         32'h0000_007F, 33'h0_0000_007F);
    drain();

`ifdef FRAME_READ_TIMEOUT_EN
    // 6: memory never acknowledges
    mem_dead = 1'b1;
    load(32'h0000_5000, 8'h00, 2'b10, 1'b0, 32'h0000_5000, 0,
         32'h0, 33'h1_0000_0000);
    repeat (15) @(posedge clock);
    #1 chk("t6_still_reading", {32'h0, mif.mem_rd}, 33'h1);
    @(posedge clock);
    #1 chk("t6_mem_rd_drop", {32'h0, mif.mem_rd}, 33'h0);
    chk("t6_rsp_valid", {32'h0, mif.rsp_valid}, 33'h1);
    drain();
    mem_dead = 1'b0;
    chk("t6_err_cleared", {32'h0, mif.rsp_err}, 33'h0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
